// File: rtl/de_pipe_reg_pkg.sv
// Shared types and constants for the D/E pipeline register.
// Holds the E-stage register bundle and Tnew helpers.
package de_pipe_reg_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
    localparam logic [31:0] RESET_PC  = 32'h0000_3000;
    localparam int          TNEW_W    = 2;

    typedef logic [TNEW_W-1:0] tnew_t;

    localparam tnew_t T0 = 2'd0;
    localparam tnew_t T1 = 2'd1;
    localparam tnew_t T2 = 2'd2;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] ext;
        logic [4:0]  reg_addr;
        logic        reg_write;
        tnew_t       tnew;
        logic        bubble;
    } id_ex_t;

    // Saturating decrement: a result that is ready stays ready.
    function automatic tnew_t tnew_sat_dec(input tnew_t t);
        return (t == T0) ? T0 : tnew_t'(t - tnew_t'(1));
    endfunction

    // Contents of the E slot after reset: a bubble at the boot PC.
    function automatic id_ex_t id_ex_reset();
        id_ex_t r;
        r           = '0;
        r.instr     = NOP_INSTR;
        r.pc        = RESET_PC;
        r.tnew      = T0;
        r.bubble    = 1'b1;
        return r;
    endfunction

    // Bubble inserted on a stall; the stalled PC is kept for exceptions.
    function automatic id_ex_t id_ex_bubble(input logic [31:0] pc);
        id_ex_t r;
        r        = '0;
        r.instr  = NOP_INSTR;
        r.pc     = pc;
        r.tnew   = T0;
        r.bubble = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/de_pipe_reg_stall_monitor.sv
// Stall statistics for the D/E register: total clr cycles,
// length of the current stall run and a sticky watchdog flag.
module stall_monitor
    import de_pipe_reg_pkg::*;
#(
    parameter int unsigned MAX_STALL = 2,
    parameter int          CNT_W     = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    output logic [CNT_W-1:0] stall_cnt,
    output logic             stall_err
);

    logic [CNT_W-1:0] cnt_nx;
    logic [2:0]       run_q;
    logic [2:0]       run_nx;
    logic             err_nx;

    // Next-state: saturating counters and the watchdog set condition.
    always_comb begin
        cnt_nx = stall_cnt;
        run_nx = 3'd0;
        err_nx = stall_err;
        if (clr) begin
            if (stall_cnt != {CNT_W{1'b1}}) begin
                cnt_nx = stall_cnt + CNT_W'(1);
            end
            if (run_q != 3'd7) begin
                run_nx = run_q + 3'd1;
            end else begin
                run_nx = run_q;
            end
            if (32'(run_nx) > MAX_STALL) begin
                err_nx = 1'b1;
            end
        end
    end

    // State registers; the error flag only clears on reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt <= '0;
            run_q     <= 3'd0;
            stall_err <= 1'b0;
        end else begin
            stall_cnt <= cnt_nx;
            run_q     <= run_nx;
            stall_err <= err_nx;
        end
    end

endmodule

// File: rtl/de_pipe_reg.sv
// D-to-E pipeline register of the 5-stage MIPS core with
// bubble insertion, Tnew hand-off and stall monitoring.
module de_pipe_reg
    import de_pipe_reg_pkg::*;
#(
    parameter int unsigned MAX_STALL = 2,
    parameter int          CNT_W     = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             clr,
    input  logic [31:0]      D_Instr,
    input  logic [31:0]      D_PC,
    input  logic [31:0]      D_RD1,
    input  logic [31:0]      D_RD2,
    input  logic [31:0]      D_EXT,
    input  logic [4:0]       D_RegAddr,
    input  logic             D_RegWrite,
    input  logic [1:0]       D_Tnew,
    output logic [31:0]      E_Instr,
    output logic [31:0]      E_PC,
    output logic [31:0]      E_RD1,
    output logic [31:0]      E_RD2,
    output logic [31:0]      E_EXT,
    output logic [4:0]       E_RegAddr,
    output logic             E_RegWrite,
    output logic [1:0]       E_Tnew,
    output logic [1:0]       EM_Tnew,
    output logic             E_Bubble,
    output logic [CNT_W-1:0] StallCnt,
    output logic             StallErr
);

    id_ex_t e_q;
    id_ex_t e_d;
    logic   wr_zero;

    assign wr_zero = (D_RegAddr == 5'd0);

    // Next E slot: clr beats en, otherwise hold.
    always_comb begin
        e_d = e_q;
        priority case (1'b1)
            clr: begin
                e_d = id_ex_bubble(D_PC);
            end
            en: begin
                e_d.instr     = D_Instr;
                e_d.pc        = D_PC;
                e_d.rd1       = D_RD1;
                e_d.rd2       = D_RD2;
                e_d.ext       = D_EXT;
                e_d.reg_addr  = D_RegAddr;
                e_d.reg_write = D_RegWrite & ~wr_zero;
                e_d.tnew      = wr_zero ? T0 : D_Tnew;
                e_d.bubble    = 1'b0;
            end
            default: begin
                e_d = e_q;
            end
        endcase
    end

    // E-stage register bank.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            e_q <= id_ex_reset();
        end else begin
            e_q <= e_d;
        end
    end

    assign E_Instr    = e_q.instr;
    assign E_PC       = e_q.pc;
    assign E_RD1      = e_q.rd1;
    assign E_RD2      = e_q.rd2;
    assign E_EXT      = e_q.ext;
    assign E_RegAddr  = e_q.reg_addr;
    assign E_RegWrite = e_q.reg_write;
    assign E_Tnew     = e_q.tnew;
    assign E_Bubble   = e_q.bubble;
    assign EM_Tnew    = tnew_sat_dec(e_q.tnew);

    stall_monitor #(
        .MAX_STALL (MAX_STALL),
        .CNT_W     (CNT_W)
    ) u_stall_monitor (
        .clk       (clk),
        .reset     (reset),
        .clr       (clr),
        .stall_cnt (StallCnt),
        .stall_err (StallErr)
    );

endmodule

// File: tb/tb_de_pipe_reg.sv
// Randomised bench for de_pipe_reg against a behavioural model,
// with directed literal checks for the key scenarios.
module tb_de_pipe_reg;

    localparam int MAXS = 2;

    logic        clk;
    logic        reset;
    logic        en;
    logic        clr;
    logic [31:0] D_Instr;
    logic [31:0] D_PC;
    logic [31:0] D_RD1;
    logic [31:0] D_RD2;
    logic [31:0] D_EXT;
    logic [4:0]  D_RegAddr;
    logic        D_RegWrite;
    logic [1:0]  D_Tnew;
    logic [31:0] E_Instr;
    logic [31:0] E_PC;
    logic [31:0] E_RD1;
    logic [31:0] E_RD2;
    logic [31:0] E_EXT;
    logic [4:0]  E_RegAddr;
    logic        E_RegWrite;
    logic [1:0]  E_Tnew;
    logic [1:0]  EM_Tnew;
    logic        E_Bubble;
    logic [31:0] StallCnt;
    logic        StallErr;

    int checks   = 0;
    int failures = 0;
    bit chk_on   = 0;

    // Behavioural model state
    logic [31:0] m_instr, m_pc, m_rd1, m_rd2, m_ext;
    logic [4:0]  m_ra;
    logic        m_rw, m_bub, m_err;
    int          m_tnew;
    longint      m_cnt;
    int          m_run;

    de_pipe_reg #(.MAX_STALL(MAXS), .CNT_W(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .clr        (clr),
        .D_Instr    (D_Instr),
        .D_PC       (D_PC),
        .D_RD1      (D_RD1),
        .D_RD2      (D_RD2),
        .D_EXT      (D_EXT),
        .D_RegAddr  (D_RegAddr),
        .D_RegWrite (D_RegWrite),
        .D_Tnew     (D_Tnew),
        .E_Instr    (E_Instr),
        .E_PC       (E_PC),
        .E_RD1      (E_RD1),
        .E_RD2      (E_RD2),
        .E_EXT      (E_EXT),
        .E_RegAddr  (E_RegAddr),
        .E_RegWrite (E_RegWrite),
        .E_Tnew     (E_Tnew),
        .EM_Tnew    (EM_Tnew),
        .E_Bubble   (E_Bubble),
        .StallCnt   (StallCnt),
        .StallErr   (StallErr)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)",
                     name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_instr = 0; m_pc = 32'h3000; m_rd1 = 0; m_rd2 = 0;
        m_ext = 0; m_ra = 0; m_rw = 0; m_tnew = 0; m_bub = 1;
        m_cnt = 0; m_run = 0; m_err = 0;
    endtask

    // What one rising edge does to the E slot and statistics.
    task automatic model_edge();
        if (clr) begin
            m_instr = 0; m_rd1 = 0; m_rd2 = 0; m_ext = 0;
            m_ra = 0; m_rw = 0; m_tnew = 0; m_bub = 1;
            m_pc = D_PC;
            if (m_cnt < 64'hFFFF_FFFF) m_cnt = m_cnt + 1;
            if (m_run < 7) m_run = m_run + 1;
            if (m_run > MAXS) m_err = 1;
        end else begin
            m_run = 0;
            if (en) begin
                m_instr = D_Instr; m_pc = D_PC; m_rd1 = D_RD1;
                m_rd2 = D_RD2; m_ext = D_EXT; m_ra = D_RegAddr;
                m_bub = 0;
                if (D_RegAddr == 0) begin
                    m_rw = 0; m_tnew = 0;
                end else begin
                    m_rw = D_RegWrite; m_tnew = int'(D_Tnew);
                end
            end
        end
    endtask

    // Full comparison of every output against the model.
    always @(negedge clk) begin
        if (chk_on) begin
            chk("instr", E_Instr, m_instr);
            chk("pc", E_PC, m_pc);
            chk("rd1", E_RD1, m_rd1);
            chk("rd2", E_RD2, m_rd2);
            chk("ext", E_EXT, m_ext);
            chk("regaddr", 32'(E_RegAddr), 32'(m_ra));
            chk("regwrite", 32'(E_RegWrite), 32'(m_rw));
            chk("tnew", 32'(E_Tnew), 32'(m_tnew));
            chk("em_tnew", 32'(EM_Tnew),
                (m_tnew == 0) ? 32'd0 : 32'(m_tnew - 1));
            chk("bubble", 32'(E_Bubble), 32'(m_bub));
            chk("stallcnt", StallCnt, m_cnt[31:0]);
            chk("stallerr", 32'(StallErr), 32'(m_err));
        end
    end

    task automatic drive(input logic [31:0] ins, input logic [31:0] pc,
                         input logic [4:0] ra, input logic rw,
                         input logic [1:0] tn, input logic e,
                         input logic c);
        D_Instr = ins; D_PC = pc; D_RegAddr = ra; D_RegWrite = rw;
        D_Tnew = tn; en = e; clr = c;
        D_RD1 = $urandom; D_RD2 = $urandom; D_EXT = $urandom;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic pulse_reset();
        #2 reset = 1;
        model_reset();
        #1;
        chk("rst_err", 32'(StallErr), 32'd0);
        chk("rst_cnt", StallCnt, 32'd0);
        chk("rst_pc", E_PC, 32'h3000);
        chk("rst_bub", 32'(E_Bubble), 32'd1);
        reset = 0;
    endtask

    initial begin
        reset = 1;
        drive(0, 0, 0, 0, 0, 0, 0);
        #2 reset = 0;
        model_reset();
        #1;
        chk("init_pc", E_PC, 32'h3000);
        chk("init_instr", E_Instr, 32'h0);
        chk("init_bub", 32'(E_Bubble), 32'd1);
        chk("init_cnt", StallCnt, 32'd0);
        chk("init_err", 32'(StallErr), 32'd0);
        chk_on = 1;

        drive(32'h8C22_0004, 32'h3004, 5'd2, 1, 2'd2, 1, 0);
        step();
        chk("lw_instr", E_Instr, 32'h8C22_0004);
        chk("lw_tnew", 32'(E_Tnew), 32'd2);
        chk("lw_emtnew", 32'(EM_Tnew), 32'd1);
        chk("lw_rw", 32'(E_RegWrite), 32'd1);
        chk("lw_bub", 32'(E_Bubble), 32'd0);

        drive(32'h0043_2020, 32'h3008, 5'd4, 1, 2'd1, 0, 1);
        step();
        chk("lu_instr", E_Instr, 32'h0);
        chk("lu_rw", 32'(E_RegWrite), 32'd0);
        chk("lu_tnew", 32'(E_Tnew), 32'd0);
        chk("lu_pc", E_PC, 32'h3008);
        chk("lu_cnt", StallCnt, 32'd1);
        chk("lu_err", 32'(StallErr), 32'd0);

        drive(32'h1234_5678, 32'h300C, 5'd7, 1, 2'd1, 1, 1);
        step();
        for (int i = 0; i < 3; i++) begin
            drive($urandom, $urandom, 5'd9, 1, 2'd2, 0, 0);
            step();
            chk("hold_pc", E_PC, 32'h300C);
            chk("hold_instr", E_Instr, 32'h0);
            chk("hold_bub", 32'(E_Bubble), 32'd1);
        end

        drive(32'h2000_0001, 32'h3010, 5'd0, 1, 2'd1, 1, 0);
        step();
        chk("r0_rw", 32'(E_RegWrite), 32'd0);
        chk("r0_tnew", 32'(E_Tnew), 32'd0);

        pulse_reset();
        for (int i = 1; i <= 3; i++) begin
            drive(0, 32'h3020, 5'd1, 1, 2'd1, 1, 1);
            step();
            chk("wd_err", 32'(StallErr), (i == 3) ? 32'd1 : 32'd0);
            chk("wd_cnt", StallCnt, 32'(i));
        end
        drive(32'h1, 32'h3024, 5'd3, 1, 2'd1, 1, 0);
        step();
        chk("wd_sticky", 32'(StallErr), 32'd1);
        drive(0, 32'h3028, 5'd3, 1, 2'd1, 1, 1);
        step();
        pulse_reset();

        for (int i = 0; i < 600; i++) begin
            logic [4:0] ra;
            ra = ($urandom_range(3) == 0) ? 5'd0 : 5'($urandom);
            drive($urandom, $urandom, ra, 1'($urandom),
                  2'($urandom_range(2)), 1'($urandom),
                  ($urandom_range(3) == 0));
            if (i % 8 < 2) clr = 1;
            step();
            if (i % 150 == 149) pulse_reset();
        end

        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/de_pipe_reg.md
Name: de_pipe_reg

Overview:
- D-to-E pipeline register of the 5-stage MIPS core; sits directly downstream of the hazard unit and consumes its stall outputs.
- Latches the decoded D-stage bundle: instruction, PC, forwarded operands, extended immediate, destination register, RegWrite and Tnew.
- Inserts a bubble (nop) when clr is asserted.
- Produces the E-stage Tnew and the saturating-decremented Tnew handed to E/M.
- Keeps stall statistics and a sticky watchdog flag that fires if stalls persist longer than any legal hazard allows.

Parameters:
- MAX_STALL, 2, largest legal number of consecutive clr cycles; exceeding it sets StallErr.
- CNT_W, 32, width of the cumulative stall counter.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- en  input  1  register enable; 0 = hold, unless clr.
- clr  input  1  bubble insert from the hazard unit; has priority over en.
- D_Instr  input  32  D-stage instruction.
- D_PC  input  32  D-stage PC.
- D_RD1  input  32  forwarded rs value.
- D_RD2  input  32  forwarded rt value.
- D_EXT  input  32  extended immediate.
- D_RegAddr  input  5  destination register.
- D_RegWrite  input  1  destination write enable.
- D_Tnew  input  2  Tnew of the D instruction, measured at E entry.
- E_Instr  output  32  registered instruction.
- E_PC  output  32  registered PC.
- E_RD1  output  32  registered rs value.
- E_RD2  output  32  registered rt value.
- E_EXT  output  32  registered immediate.
- E_RegAddr  output  5  registered destination register.
- E_RegWrite  output  1  registered write enable.
- E_Tnew  output  2  current E-stage Tnew.
- EM_Tnew  output  2  combinational sat(E_Tnew-1), for the E/M register.
- E_Bubble  output  1  1 when the E slot holds an inserted bubble.
- StallCnt  output  CNT_W  cumulative count of clr cycles.
- StallErr  output  1  sticky watchdog flag.

Behaviour:
- Reset (async, immediate):
  - All data outputs = 0; E_PC = 32'h0000_3000.
  - E_Bubble = 1; StallCnt = 0; StallErr = 0; consecutive counter = 0.
- Each rising clk, priority is clr > en > hold.
- clr=1:
  - E_Instr = 0 (nop); E_RD1, E_RD2, E_EXT, E_RegAddr, E_RegWrite, E_Tnew = 0; E_Bubble = 1.
  - E_PC = D_PC, so the PC of the stalled instruction is retained for later exception reporting.
- clr=0, en=1:
  - All E_* take the corresponding D_* values; E_Bubble = 0.
  - Exception: if D_RegAddr = 0, E_RegWrite and E_Tnew are forced to 0. Writes to $0 never create hazards.
- clr=0, en=0: all E_* registers hold their values.
- Latency: 1 cycle from D inputs to E outputs.
- EM_Tnew = (E_Tnew == 0) ? 0 : E_Tnew - 1. Purely combinational; it never wraps below 0.
- StallCnt: increments by 1 on every clk edge with clr=1. It saturates at all-ones and does not wrap.
- Consecutive counter (3 bits, saturating at 7):
  - Increments on each clk with clr=1; resets to 0 on any clk with clr=0.
  - StallErr is set when the counter value after the update exceeds MAX_STALL. It clears only on reset.
- With default MAX_STALL=2: 3 consecutive clr cycles set StallErr on the 3rd edge.
- clr and en both 1: treated exactly as clr.
- reset asserted mid-stall: everything returns to reset values, including StallErr and both counters.

Decomposition:
- Shared package: NOP_INSTR (32'h0), RESET_PC (32'h0000_3000), TNEW_W (2), and the Tnew encodings T0, T1, T2.
- One sub-module, stall_monitor: StallCnt, the consecutive counter and StallErr; inputs are clk, reset and clr.
- The register bank and the EM_Tnew decrement stay in the top module.

Test Plan:
- Reset then release, no clocks → E_PC = 32'h3000, E_Instr = 0, E_Bubble = 1, StallCnt = 0, StallErr = 0.
- en=1, clr=0, D_Instr = 32'h8C22_0004 (lw), D_RegAddr = 2, D_Tnew = 2, one edge → E_Instr = 8C220004, E_Tnew = 2, EM_Tnew = 1, E_RegWrite = 1, E_Bubble = 0.
- Load-use: clr=1 for one edge with D_PC = 32'h3008 → E_Instr = 0, E_RegWrite = 0, E_Tnew = 0, E_PC = 3008, StallCnt = 1, StallErr = 0.
- clr=1 and en=1 together, followed by en=0/clr=0 for 3 edges → bubble inserted on the first edge, then held unchanged for 3 cycles.
- D_RegAddr = 0, D_RegWrite = 1, D_Tnew = 1, en=1 → E_RegWrite = 0, E_Tnew = 0.
- clr=1 for 3 consecutive edges → StallErr = 1 after the 3rd edge, StallCnt = 3. StallErr stays 1 after clr drops. Pulsing reset mid-stall → StallErr = 0 and StallCnt = 0 immediately.
